tdm_sample_tx: RTL and testbench
================================

Name: tdm_sample_tx

Overview:
Serialiser on the output side of the audio core interface. It captures the four parallel signed samples a core presents on a sample_clk strobe and double-buffers them. It then shifts them MSB-first onto a 4-slot TDM serial line, generating bit clock and frame sync from the single system clock. Its frame_strobe output is the per-frame pulse that downstream/upstream cores use as sample_clk.

Parameters:
W, 16, sample width in bits (two's complement)
SLOT_BITS, 32, bits per TDM slot; must be >= W; frame = 4*SLOT_BITS bits

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
sample_clk  input  1  one-cycle strobe: sample_in0..3 valid this cycle
sample_in0  input  W  slot 0 sample
sample_in1  input  W  slot 1 sample
sample_in2  input  W  slot 2 sample
sample_in3  input  W  slot 3 sample
clr_status  input  1  one-cycle pulse, clears sticky flags
bclk  output  1  bit clock, clk/2
fsync  output  1  frame sync, high for bit 0 of each frame
sdout  output  1  serial data
frame_strobe  output  1  one-cycle pulse at start of each frame
underrun  output  1  sticky: frame loaded with no new samples
overrun  output  1  sticky: pending samples overwritten before use

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- State: bit counter b in 0..4*SLOT_BITS-1 and phase p in {0,1}. Each bit lasts 2 clk cycles (p=0, then p=1). Advance: p 0->1; on p 1->0, b increments and wraps to 0.
- All outputs are registered. In a cycle with state (b,p): bclk=p, fsync=(b==0), sdout=MSB of shift register. sdout changes only at p=0 entry (bclk falling edge); the receiver samples on the bclk rising edge.
- Frame load happens on entry to (b=0,p=0), i.e. the cycle after (b=last,p=1):
  - if pending=1: shift register <= {in0,pad,in1,pad,in2,pad,in3,pad}. Each sample is left-justified in its slot with SLOT_BITS-W zero LSBs. The loaded set is copied to the hold register; pending cleared.
  - if pending=0: reload from the hold register (repeat previous frame); set underrun.
- frame_strobe=1 exactly in cycles where (b=0,p=0), so once per 8*SLOT_BITS clk cycles.
- Shift: on each p 1->0 transition other than the wrap, the shift register shifts left by 1, zero-fill.
- Capture: on sample_clk=1, the pending register <= sample_in0..3. If pending was already 1 and no load consumes it this cycle, set overrun; the newest samples win.
- Simultaneous sample_clk and frame load: the load uses pending state from before the cycle. The new samples go into pending for the next frame, with pending=1 afterwards. There is no bypass; minimum latency from capture to MSB on sdout is one full frame boundary.
- Sticky flags: set on their event and cleared by clr_status. Set wins when set and clear occur in the same cycle.
- Reset (any time, including mid-frame): b=0, p=0, pending=0, and shift, hold and pending registers all zero; bclk=0, fsync=0, sdout=0, frame_strobe=0, underrun=0, overrun=0.
  - First cycle after rst_n rises is state (0,0) with no load. frame_strobe=1, fsync=1, and the frame transmits zeros.
  - No underrun is flagged for this first frame; the next wrap performs a normal load.

Optional Feature:
TDM_TX_UNDERRUN_CNT_EN: when defined, adds output underrun_count [7:0]. It increments on each underrun load event, saturates at 255, resets to 0, and is cleared by clr_status (increment wins if both occur in the same cycle). When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with random inputs -> all outputs 0. After release: fsync=1 and frame_strobe=1 in the first cycle, and the first frame is all-zero sdout.
- Single frame: sample_clk with in0=16'h8001, in1=16'h7FFE, in2=0, in3=16'hFFFF. The next frame's sdout stream (sampled on bclk rise) is 8001 0000 7FFE 0000 0000 0000 FFFF 0000 hex MSB-first; fsync is high only during bit 0; frame_strobe period is 256 clk.
- Underrun: no sample_clk after one loaded frame -> the next frame repeats the identical 128 bits and underrun=1. clr_status -> underrun=0.
- Overrun: two sample_clk strobes (values A then B) within one frame -> the next frame carries B and overrun=1.
- Simultaneous: sample_clk with value C in the exact load cycle while pending holds D -> this frame carries D, the next carries C, and no overrun is flagged.
- Mid-frame reset: assert rst_n=0 at bit 70 -> outputs zero next cycle. Release restarts at bit 0 with a zero frame. With TDM_TX_UNDERRUN_CNT_EN, 300 consecutive underruns -> underrun_count=255.

Source files
------------

// File: rtl/tdm_sample_tx.sv
// tdm_sample_tx: captures four parallel samples, double-buffers them and shifts them MSB-first onto a 4-slot TDM line.
// Latency: samples captured in one frame go out on sdout in the next frame. There is no bypass into the frame being loaded.
// Backpressure: none. A second capture before the next frame load overwrites the pending set and raises overrun.
//
// Ports:
//   clk, rst_n                 system clock, synchronous active-low reset
//   sample_clk                 one-cycle capture strobe for sample_in0..3
//   sample_in0..sample_in3     W-bit two's complement samples for slots 0..3
//   clr_status                 one-cycle pulse, clears the sticky flags (and the counter)
//   bclk, fsync, sdout         TDM bit clock (clk/2), frame sync (bit 0 only) and serial data
//   frame_strobe               one-cycle pulse at the start of each frame (acts as sample_clk for cores)
//   underrun, overrun          sticky status flags
//   underrun_count [7:0]       saturating underrun counter, present only with TDM_TX_UNDERRUN_CNT_EN
//
// Optional feature macro: TDM_TX_UNDERRUN_CNT_EN
module tdm_sample_tx #(
  parameter int W         = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sample_clk,
  input  logic [W-1:0] sample_in0,
  input  logic [W-1:0] sample_in1,
  input  logic [W-1:0] sample_in2,
  input  logic [W-1:0] sample_in3,
  input  logic         clr_status,
  output logic         bclk,
  output logic         fsync,
  output logic         sdout,
  output logic         frame_strobe,
  output logic         underrun,
  output logic         overrun
`ifdef TDM_TX_UNDERRUN_CNT_EN
  ,
  output logic [7:0]   underrun_count
`endif
);

  localparam int FB = 4 * SLOT_BITS;
  localparam int BW = $clog2(FB);

  typedef logic [BW-1:0] bcnt_t;
  localparam bcnt_t B_LAST = bcnt_t'(FB - 1);

  // r_run is low for the first cycle after reset; the frame counter holds
  // (0,0) for that cycle so the first frame starts without a load.
  logic          r_run;
  bcnt_t         r_b;
  logic          r_p;
  logic [FB-1:0] r_shift;
  logic [FB-1:0] r_hold;
  logic          r_pend;
  logic [4*W-1:0] r_pend_dat;
  logic          r_fsync;
  logic          r_fstrobe;
  logic          r_underrun;
  logic          r_overrun;

  logic          w_wrap;
  logic          w_underrun_evt;
  logic          w_overrun_evt;
  bcnt_t         w_next_b;
  logic          w_next_p;
  logic [FB-1:0] w_pend_frame;

  // Load happens on the edge leaving the last half-bit of the frame.
  assign w_wrap         = r_run & r_p & (r_b == B_LAST);
  assign w_underrun_evt = w_wrap & ~r_pend;
  // A load in the same cycle consumes the old pending set, so no overrun then.
  assign w_overrun_evt  = sample_clk & r_pend & ~w_wrap;

  // Each sample is left-justified in its slot, padding LSBs are zero.
  always_comb begin
    w_pend_frame = '0;
    for (int i = 0; i < 4; i++) begin
      w_pend_frame[FB-1-i*SLOT_BITS -: W] = r_pend_dat[4*W-1-i*W -: W];
    end
  end

  always_comb begin
    w_next_p = r_p;
    w_next_b = r_b;
    if (r_run) begin
      w_next_p = ~r_p;
      if (r_p) begin
        w_next_b = (r_b == B_LAST) ? '0 : r_b + bcnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_b        <= '0;
      r_p        <= 1'b0;
      r_shift    <= '0;
      r_hold     <= '0;
      r_pend     <= 1'b0;
      r_pend_dat <= '0;
      r_fsync    <= 1'b0;
      r_fstrobe  <= 1'b0;
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_run     <= 1'b1;
      r_b       <= w_next_b;
      r_p       <= w_next_p;
      // Output flags are registered from the next state so they line up
      // with the (b,p) state of the cycle they are presented in.
      r_fsync   <= (w_next_b == '0);
      r_fstrobe <= (w_next_b == '0) & ~w_next_p;

      if (w_wrap) begin
        if (r_pend) begin
          r_shift <= w_pend_frame;
          r_hold  <= w_pend_frame;
        end else begin
          r_shift <= r_hold;
        end
      end else if (r_run && r_p) begin
        r_shift <= {r_shift[FB-2:0], 1'b0};
      end

      if (sample_clk) begin
        r_pend     <= 1'b1;
        r_pend_dat <= {sample_in0, sample_in1, sample_in2, sample_in3};
      end else if (w_wrap) begin
        r_pend <= 1'b0;
      end

      r_underrun <= w_underrun_evt | (r_underrun & ~clr_status);
      r_overrun  <= w_overrun_evt  | (r_overrun  & ~clr_status);
    end
  end

  assign bclk         = r_p;
  assign fsync        = r_fsync;
  assign sdout        = r_shift[FB-1];
  assign frame_strobe = r_fstrobe;
  assign underrun     = r_underrun;
  assign overrun      = r_overrun;

`ifdef TDM_TX_UNDERRUN_CNT_EN
  logic [7:0] r_ur_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ur_cnt <= '0;
    end else if (w_underrun_evt) begin
      if (r_ur_cnt != 8'hFF) begin
        r_ur_cnt <= r_ur_cnt + 8'd1;
      end
    end else if (clr_status) begin
      r_ur_cnt <= '0;
    end
  end

  assign underrun_count = r_ur_cnt;
`endif

endmodule

// File: tb/tb_tdm_sample_tx.sv
// tb_tdm_sample_tx: directed, table-driven bench for the TDM serialiser.
// Latency: frames are captured cycle by cycle from one frame_strobe to the next.
// Backpressure: none; stimulus is driven on falling edges, outputs sampled there too.
module tb_tdm_sample_tx;

  logic        clk;
  logic        rst_n;
  logic        sample_clk;
  logic [15:0] s0, s1, s2, s3;
  logic        clr_status;
  logic        bclk, fsync, sdout, frame_strobe, underrun, overrun;
`ifdef TDM_TX_UNDERRUN_CNT_EN
  logic [7:0]  underrun_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  tdm_sample_tx #(.W(16), .SLOT_BITS(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_clk   (sample_clk),
    .sample_in0   (s0),
    .sample_in1   (s1),
    .sample_in2   (s2),
    .sample_in3   (s3),
    .clr_status   (clr_status),
    .bclk         (bclk),
    .fsync        (fsync),
    .sdout        (sdout),
    .frame_strobe (frame_strobe),
    .underrun     (underrun),
    .overrun      (overrun)
`ifdef TDM_TX_UNDERRUN_CNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  smp;    // {in0,in1,in2,in3}
    logic [127:0] frame;  // expected serial frame, MSB first
    logic         under;  // underrun expected after this frame ends
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [63:0] v);
    {s0, s1, s2, s3} = v;
    sample_clk = 1'b1;
  endtask

  // Called at the falling edge of frame cycle 0; returns at cycle 0 of the next frame.
  // st_a/st_b: cycle indices (0..255) to strobe va/vb; clr_c: cycle to pulse clr_status.
  task automatic capture_frame(input string nm, input logic [127:0] exp_f,
                               input int st_a, input logic [63:0] va,
                               input int st_b, input logic [63:0] vb,
                               input int clr_c);
    logic [127:0] f;
    int tbad;
    f = '0;
    tbad = 0;
    for (int c = 0; c < 256; c++) begin
      if (bclk !== ((c % 2) != 0)) tbad++;
      if (fsync !== (c < 2)) tbad++;
      if (frame_strobe !== (c == 0)) tbad++;
      if ((c % 2) == 1) f[127 - c/2] = sdout;
      sample_clk = 1'b0;
      clr_status = 1'b0;
      if (c == st_a) drive(va);
      if (c == st_b) drive(vb);
      if (c == clr_c) clr_status = 1'b1;
      @(negedge clk);
    end
    sample_clk = 1'b0;
    clr_status = 1'b0;
    if (frame_strobe !== 1'b1) tbad++;
    check($sformatf("%s_data", nm), f, exp_f);
    check($sformatf("%s_timing", nm), 128'(tbad), 128'd0);
  endtask

  task automatic check_flags(input string nm, input logic exp_u, input logic exp_o);
    check(nm, {126'd0, underrun, overrun}, {126'd0, exp_u, exp_o});
  endtask

  localparam logic [63:0]  VA = 64'h1111_2222_3333_4444;
  localparam logic [63:0]  VB = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [127:0] FB_B = 128'hAAAA_0000_BBBB_0000_CCCC_0000_DDDD_0000;
  localparam logic [63:0]  VC = 64'hF00F_0FF0_8888_7777;
  localparam logic [127:0] FB_C = 128'hF00F_0000_0FF0_0000_8888_0000_7777_0000;
  localparam logic [63:0]  VD = 64'h0102_0304_0506_0708;
  localparam logic [127:0] FB_D = 128'h0102_0000_0304_0000_0506_0000_0708_0000;
  localparam logic [63:0]  VE = 64'h7E7E_1234_4321_0F0F;

  initial begin
    tbl[0] = '{smp: 64'h8001_7FFE_0000_FFFF,
               frame: 128'h8001_0000_7FFE_0000_0000_0000_FFFF_0000, under: 1'b0};
    tbl[1] = '{smp: 64'h1234_ABCD_5555_AAAA,
               frame: 128'h1234_0000_ABCD_0000_5555_0000_AAAA_0000, under: 1'b0};
    tbl[2] = '{smp: 64'hFFFF_FFFF_FFFF_FFFF,
               frame: 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, under: 1'b0};
    tbl[3] = '{smp: 64'h0001_8000_00F0_0F00,
               frame: 128'h0001_0000_8000_0000_00F0_0000_0F00_0000, under: 1'b1};

    rst_n = 1'b0;
    sample_clk = 1'b0;
    clr_status = 1'b0;
    {s0, s1, s2, s3} = '0;

    // Reset held with random inputs: every output stays low.
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      s0 = 16'($urandom); s1 = 16'($urandom); s2 = 16'($urandom); s3 = 16'($urandom);
      sample_clk = 1'($urandom_range(0, 1));
      clr_status = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("rst_out%0d", i),
            {122'd0, bclk, fsync, sdout, frame_strobe, underrun, overrun}, 128'd0);
    end
    sample_clk = 1'b0;
    clr_status = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("release_sync", {125'd0, fsync, frame_strobe, bclk}, {125'd0, 1'b1, 1'b1, 1'b0});

    // First frame after reset transmits zeros; V0 captured during it.
    capture_frame("reset_frame", 128'd0, 10, tbl[0].smp, -1, '0, -1);
    check_flags("reset_frame_flags", 1'b0, 1'b0);

    // Table: each frame carries the previous strobe, next vector strobed meanwhile.
    for (int i = 0; i < 4; i++) begin
      capture_frame($sformatf("vec%0d", i), tbl[i].frame,
                    (i < 3) ? 40 : -1, (i < 3) ? tbl[i+1].smp : 64'd0, -1, '0, -1);
      check_flags($sformatf("vec%0d_flags", i), tbl[i].under, 1'b0);
    end

    // Repeat of the last frame; clear at the underrun load edge loses to set.
    capture_frame("repeat", tbl[3].frame, -1, '0, -1, '0, 255);
    check_flags("repeat_setwins", 1'b1, 1'b0);

    // Clear underrun, then two strobes in one frame: B wins, overrun raised.
    capture_frame("repeat2", tbl[3].frame, 20, VA, 100, VB, 3);
    check_flags("overrun_flags", 1'b0, 1'b1);

    // B goes out; clear overrun; D pending, C strobed in the load cycle.
    capture_frame("frame_b", FB_B, 30, VD, 255, VC, 5);
    check_flags("simul_flags", 1'b0, 1'b0);
    capture_frame("frame_d", FB_D, -1, '0, -1, '0, -1);
    check_flags("frame_d_flags", 1'b0, 1'b0);
    capture_frame("frame_c", FB_C, -1, '0, -1, '0, -1);
    check_flags("frame_c_flags", 1'b1, 1'b0);

    // Mid-frame reset at bit 70 with E pending; pending and hold must be wiped.
    for (int c = 0; c < 140; c++) begin
      sample_clk = 1'b0;
      if (c == 50) drive(VE);
      @(negedge clk);
    end
    sample_clk = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out", {122'd0, bclk, fsync, sdout, frame_strobe, underrun, overrun}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_release", {125'd0, fsync, frame_strobe, underrun}, {125'd0, 1'b1, 1'b1, 1'b0});
`ifdef TDM_TX_UNDERRUN_CNT_EN
    check("cnt_after_reset", {120'd0, underrun_count}, 128'd0);
`endif
    capture_frame("midrst_zero", 128'd0, -1, '0, -1, '0, -1);
    check_flags("midrst_zero_flags", 1'b1, 1'b0);
    capture_frame("midrst_repeat", 128'd0, -1, '0, -1, '0, -1);
    check_flags("midrst_repeat_flags", 1'b1, 1'b0);

`ifdef TDM_TX_UNDERRUN_CNT_EN
    // Two underruns so far; 300 more frames must saturate the counter.
    repeat (300 * 256) @(negedge clk);
    check("cnt_saturate", {120'd0, underrun_count}, {120'd0, 8'hFF});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
